// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the round-robin APB master.
package apb_ctrl_pkg;

    localparam int APB_ADDR_W         = 8;
    localparam int APB_DATA_W         = 8;
    localparam int DEFAULT_ADDR_LIMIT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Pointer width; a single-bit pointer is kept even for degenerate counts.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr, plus the
// pointer value that follows the winner when advance is set.
module rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PW      = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      ptr_next
);

    int         idx;
    int         nxt;
    logic       found;
    logic [PW-1:0] sel;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        nxt      = 0;
        sel      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = PW'(idx);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                nxt        = idx + 1;
                if (nxt >= NUM_REQ) begin
                    nxt = 0;
                end
                if (advance) begin
                    ptr_next = PW'(nxt);
                end
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Multi-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// one completion pulse per transfer. Optional ACCESS timeout: APB_TIMEOUT_EN.
module apb_rr_master
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_LIMIT     = DEFAULT_ADDR_LIMIT,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [APB_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [APB_DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [APB_DATA_W-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [APB_ADDR_W-1:0]         PADDR,
    output logic [APB_DATA_W-1:0]         PWDATA,
    input  logic [APB_DATA_W-1:0]         PRDATA,
    input  logic                          PREADY
);

    localparam int PW = ptr_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("apb_rr_master: parameter out of range");
    end

    state_e                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_q, tmo_d;
`endif

    logic [NUM_REQ-1:0]    arb_grant;
    logic [PW-1:0]         arb_ptr_next;
    logic [PW-1:0]         win_idx;
    logic                  win_write;
    logic [APB_ADDR_W-1:0] win_addr;
    logic [APB_DATA_W-1:0] win_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr_q),
        .advance  (state_q == IDLE),
        .grant    (arb_grant),
        .ptr_next (arb_ptr_next)
    );

    // Grants exist only in IDLE, and never while reset is held.
    assign req_grant = (state_q == IDLE && PRESETn) ? arb_grant : '0;

    always_comb begin
        win_idx   = '0;
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_grant[i]) begin
                win_idx   = PW'(i);
                win_write = req_write[i];
                win_addr  = req_addr[APB_ADDR_W*i +: APB_ADDR_W];
                win_wdata = req_wdata[APB_DATA_W*i +: APB_DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_grant != '0) begin
                    ptr_d    = arb_ptr_next;
                    owner_d  = win_idx;
                    pwrite_d = win_write;
                    paddr_d  = win_addr;
                    pwdata_d = win_wdata;
                    if (int'(win_addr) >= ADDR_LIMIT) begin
                        // Rejected without touching the bus.
                        state_d     = RESP;
                        rsp_valid_d = req_grant;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                tmo_d     = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d              = RESP;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = pwrite_q ? '0 : PRDATA;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d              = RESP;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a 64x8 APB slave model and a
// response scoreboard keyed on {cycle, owner, err, rdata}.
module tb_apb_rr_master;

    localparam int W = 43;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_grant;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr, pwdata, prdata;
    logic        pready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    logic [7:0] mem [0:63];
    logic       hang = 1'b0;
    int         wait_states = 0;
    int         acc_cnt = 0;

    apb_rr_master #(
        .NUM_REQ        (2),
        .ADDR_LIMIT     (64),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK      (clk),
        .PRESETn   (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_grant (req_grant),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model
    assign pready = !hang && (acc_cnt >= wait_states);
    assign prdata = mem[paddr[5:0]];
    always @(posedge clk) begin
        if (psel && penable && pready) begin
            if (pwrite) mem[paddr[5:0]] <= pwdata;
            acc_cnt <= 0;
        end else if (psel && penable) begin
            acc_cnt <= acc_cnt + 1;
        end else begin
            acc_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] act;
        logic [1:0]   own;
        if (rst_n && rsp_valid != '0) begin
            chk("rsp_onehot", 64'($countones(rsp_valid)), 64'(1));
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e   = exp_q.pop_front();
                own = rsp_valid[1] ? 2'd1 : 2'd0;
                act = {32'(cyc), own, rsp_err, rsp_rdata};
                chk("rsp_cyc_owner_err_rdata", 64'(act), 64'(e));
            end
        end
    end

    // Drivers
    task automatic issue(input int idx, input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                         input int lat, input logic [7:0] erd, input logic eerr, input bit push);
        int         g;
        bit         got;
        logic [1:0] onehot;
        got    = 1'b0;
        g      = 0;
        onehot = 2'b01 << idx;
        if (idx == 0) begin
            req_write[0] = wr; req_addr[7:0] = addr; req_wdata[7:0] = wd; req_valid[0] = 1'b1;
        end else begin
            req_write[1] = wr; req_addr[15:8] = addr; req_wdata[15:8] = wd; req_valid[1] = 1'b1;
        end
        for (int t = 0; t < 20; t++) begin
            #1;
            if ((req_grant & onehot) != '0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("grant_seen", 64'(got), 64'(1));
        if (got) begin
            chk("grant_onehot", 64'(req_grant), 64'(onehot));
            g = cyc;
            if (push) exp_q.push_back({32'(g + lat), 2'(idx), eerr, erd});
            @(posedge clk);
            @(negedge clk);
        end
        if (idx == 0) req_valid[0] = 1'b0;
        else          req_valid[1] = 1'b0;
    endtask

    task automatic check_phases(input logic wr, input logic [7:0] addr, input logic [7:0] wd, input int n_acc);
        #1;
        chk("setup_phase", 64'({psel, penable, pwrite, paddr, pwdata}), 64'({1'b1, 1'b0, wr, addr, wd}));
        for (int k = 0; k < n_acc; k++) begin
            @(negedge clk);
            #1;
            chk("access_phase", 64'({psel, penable, pwrite, paddr, pwdata}), 64'({1'b1, 1'b1, wr, addr, wd}));
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_drain", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_outputs",
            64'({psel, penable, pwrite, paddr, pwdata, req_grant, rsp_valid, rsp_rdata, rsp_err}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         got;
        int         prev;
        logic [1:0] exp_g;

        // Reset state
        apply_reset();
        #1;
        chk("reset_state",
            64'({psel, penable, pwrite, paddr, pwdata, req_grant, rsp_valid, rsp_rdata, rsp_err}), 64'(0));
        @(negedge clk);

        // 1: write then read back
        issue(0, 1'b1, 8'h05, 8'hA5, 3, 8'h00, 1'b0, 1'b1);
        check_phases(1'b1, 8'h05, 8'hA5, 1);
        wait_done();
        issue(0, 1'b0, 8'h05, 8'h00, 3, 8'hA5, 1'b0, 1'b1);
        check_phases(1'b0, 8'h05, 8'h00, 1);
        wait_done();

        // 2: round robin with both requesters held from reset
        apply_reset();
        req_write = 2'b11;
        req_addr  = {8'h20, 8'h10};
        req_wdata = {8'h22, 8'h11};
        req_valid = 2'b11;
        got = 0;
        prev = 0;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (req_grant != '0) begin
                exp_g = (got % 2 == 0) ? 2'b01 : 2'b10;
                chk("rr_onehot", 64'($countones(req_grant)), 64'(1));
                chk("rr_order", 64'(req_grant), 64'(exp_g));
                if (got > 0) chk("rr_spacing", 64'(cyc - prev), 64'(4));
                exp_q.push_back({32'(cyc + 3), (req_grant[1] ? 2'd1 : 2'd0), 1'b0, 8'h00});
                prev = cyc;
                got++;
            end
            if (got == 4) break;
            @(negedge clk);
        end
        chk("rr_grant_count", 64'(got), 64'(4));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_done();
        issue(0, 1'b0, 8'h10, 8'h00, 3, 8'h11, 1'b0, 1'b1);
        wait_done();
        issue(1, 1'b0, 8'h20, 8'h00, 3, 8'h22, 1'b0, 1'b1);
        wait_done();

        // 3: illegal addresses and the last legal one
        issue(1, 1'b0, 8'h40, 8'h00, 1, 8'h00, 1'b1, 1'b1);
        #1;
        chk("illegal_no_psel", 64'({psel, penable}), 64'(0));
        wait_done();
        issue(0, 1'b1, 8'hFF, 8'h99, 1, 8'h00, 1'b1, 1'b1);
        #1;
        chk("illegal_no_psel", 64'({psel, penable}), 64'(0));
        wait_done();
        issue(1, 1'b1, 8'h3F, 8'h5A, 3, 8'h00, 1'b0, 1'b1);
        check_phases(1'b1, 8'h3F, 8'h5A, 1);
        wait_done();
        issue(0, 1'b0, 8'h3F, 8'h00, 3, 8'h5A, 1'b0, 1'b1);
        wait_done();

        // 4: three wait states
        wait_states = 3;
        issue(1, 1'b1, 8'h22, 8'h3C, 6, 8'h00, 1'b0, 1'b1);
        check_phases(1'b1, 8'h22, 8'h3C, 4);
        wait_done();
        issue(0, 1'b0, 8'h22, 8'h00, 6, 8'h3C, 1'b0, 1'b1);
        check_phases(1'b0, 8'h22, 8'h00, 4);
        wait_done();
        wait_states = 0;

        // 5a: reset mid-ACCESS, then both valid -> req0 first
        hang = 1'b1;
        issue(0, 1'b1, 8'h30, 8'h77, 0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        mid_reset();
        hang = 1'b0;
        req_write[1] = 1'b0; req_addr[15:8] = 8'h10; req_wdata[15:8] = 8'h00; req_valid[1] = 1'b1;
        issue(0, 1'b0, 8'h05, 8'h00, 3, 8'hA5, 1'b0, 1'b1);
        issue(1, 1'b0, 8'h10, 8'h00, 3, 8'h11, 1'b0, 1'b1);
        wait_done();

        // 5b: reset mid-ACCESS, then only req1 valid
        hang = 1'b1;
        issue(0, 1'b1, 8'h31, 8'h66, 0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        mid_reset();
        hang = 1'b0;
        issue(1, 1'b0, 8'h10, 8'h00, 3, 8'h11, 1'b0, 1'b1);
        wait_done();

        // 6: slave never ready
        hang = 1'b1;
`ifdef APB_TIMEOUT_EN
        issue(0, 1'b0, 8'h05, 8'h00, 6, 8'h00, 1'b1, 1'b1);
        check_phases(1'b0, 8'h05, 8'h00, 4);
        @(negedge clk);
        #1;
        chk("timeout_psel_drop", 64'({psel, penable}), 64'(0));
        hang = 1'b0;
        wait_done();
`else
        issue(0, 1'b0, 8'h05, 8'h00, 0, 8'h00, 1'b0, 1'b0);
        check_phases(1'b0, 8'h05, 8'h00, 30);
        @(negedge clk);
        mid_reset();
        hang = 1'b0;
        repeat (4) @(negedge clk);
        wait_done();
`endif

        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
